// File: rtl/sprite_layer_renderer.sv
// Composites up to NUM_SPRITES frame-strip sprites over a live background colour.
// Fixed three-stage pipeline: address/hit, ROM read, output register.
module sprite_layer_renderer #(
    parameter int NUM_SPRITES = 4,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64,
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_W     = 2,
    parameter int COLOR_WIDTH = 12,
    parameter int ADDR_WIDTH  = 14,
    parameter logic [COLOR_WIDTH-1:0] TRANSPARENT = 12'hF0F
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [10:0]                    curr_x,
    input  logic [9:0]                     curr_y,
    input  logic                           video_en,
    input  logic                           frame_start,
    input  logic [11*NUM_SPRITES-1:0]      spr_pos_x,
    input  logic [10*NUM_SPRITES-1:0]      spr_pos_y,
    input  logic [FRAME_W*NUM_SPRITES-1:0] spr_frame,
    input  logic [NUM_SPRITES-1:0]         spr_en,
    input  logic [COLOR_WIDTH-1:0]         bg_color,
    output logic [ADDR_WIDTH-1:0]          rom_addr,
    input  logic [COLOR_WIDTH-1:0]         rom_data,
    output logic [3:0]                     o_pix_r,
    output logic [3:0]                     o_pix_g,
    output logic [3:0]                     o_pix_b,
    output logic                           o_video_en,
    output logic                           o_hit_valid,
    output logic [2:0]                     o_hit_id
);

    localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;

    logic [11*NUM_SPRITES-1:0]      pos_x_q;
    logic [10*NUM_SPRITES-1:0]      pos_y_q;
    logic [FRAME_W*NUM_SPRITES-1:0] frame_q;
    logic [NUM_SPRITES-1:0]         en_q;

    logic [NUM_SPRITES-1:0] hit_vec;
    logic [11:0]            px     [NUM_SPRITES];
    logic [10:0]            py     [NUM_SPRITES];
    logic [11:0]            dx     [NUM_SPRITES];
    logic [10:0]            dy     [NUM_SPRITES];
    logic                   hit_d;
    logic [2:0]             id_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    int                     lin;

    logic                   hit_a_q, hit_b_q, ven_a_q, ven_b_q;
    logic [2:0]             id_a_q, id_b_q;
    logic [COLOR_WIDTH-1:0] pix_d, pix_q;
    logic                   out_hit_d, out_hit_q, out_ven_q;
    logic [2:0]             out_id_d, out_id_q;

    // Attributes only change between frames so a sprite never tears mid-frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
            frame_q <= '0;
            en_q    <= '0;
        end else if (frame_start) begin
            pos_x_q <= spr_pos_x;
            pos_y_q <= spr_pos_y;
            frame_q <= spr_frame;
            en_q    <= spr_en;
        end
    end

    // Bounds use one extra bit so sprites near the right/bottom edge cannot wrap to 0.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            px[i] = {1'b0, pos_x_q[11*i +: 11]};
            py[i] = {1'b0, pos_y_q[10*i +: 10]};
            dx[i] = {1'b0, curr_x} - px[i];
            dy[i] = {1'b0, curr_y} - py[i];
            hit_vec[i] = en_q[i]
                && (int'(frame_q[FRAME_W*i +: FRAME_W]) < NUM_FRAMES)
                && ({1'b0, curr_x} >= px[i]) && ({1'b0, curr_x} < px[i] + 12'(IMG_WIDTH))
                && ({1'b0, curr_y} >= py[i]) && ({1'b0, curr_y} < py[i] + 11'(IMG_HEIGHT));
        end
    end

    // Walk from highest to lowest index so the lowest-indexed hit overwrites the rest.
    always_comb begin
        hit_d  = 1'b0;
        id_d   = '0;
        addr_d = '0;
        lin    = 0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                lin    = int'(frame_q[FRAME_W*i +: FRAME_W]) * FRAME_PIXELS
                       + int'(dy[i]) * IMG_WIDTH + int'(dx[i]);
                hit_d  = 1'b1;
                id_d   = 3'(i);
                addr_d = ADDR_WIDTH'(lin);
            end
        end
        if (!video_en) begin
            hit_d  = 1'b0;
            id_d   = '0;
            addr_d = '0;
        end
    end

    always_comb begin
        pix_d     = '0;
        out_hit_d = 1'b0;
        out_id_d  = '0;
        if (ven_b_q) begin
            if (hit_b_q && (rom_data != TRANSPARENT)) begin
                pix_d     = rom_data;
                out_hit_d = 1'b1;
                out_id_d  = id_b_q;
            end else begin
                pix_d = bg_color;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rom_addr  <= '0;
            hit_a_q   <= 1'b0;
            id_a_q    <= '0;
            ven_a_q   <= 1'b0;
            hit_b_q   <= 1'b0;
            id_b_q    <= '0;
            ven_b_q   <= 1'b0;
            pix_q     <= '0;
            out_hit_q <= 1'b0;
            out_id_q  <= '0;
            out_ven_q <= 1'b0;
        end else begin
            rom_addr  <= addr_d;
            hit_a_q   <= hit_d;
            id_a_q    <= id_d;
            ven_a_q   <= video_en;
            hit_b_q   <= hit_a_q;
            id_b_q    <= id_a_q;
            ven_b_q   <= ven_a_q;
            pix_q     <= pix_d;
            out_hit_q <= out_hit_d;
            out_id_q  <= out_id_d;
            out_ven_q <= ven_b_q;
        end
    end

    assign o_pix_r     = pix_q[11:8];
    assign o_pix_g     = pix_q[7:4];
    assign o_pix_b     = pix_q[3:0];
    assign o_video_en  = out_ven_q;
    assign o_hit_valid = out_hit_q;
    assign o_hit_id    = out_id_q;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Randomised and directed bench for sprite_layer_renderer, checked against a
// coordinate-level reference model with a behavioural synchronous ROM.
module tb_sprite_layer_renderer;

    localparam int NS = 4;
    localparam int IW = 64;
    localparam int IH = 64;
    localparam int NF = 4;
    localparam int FW = 3;
    localparam int AW = 14;
    localparam logic [11:0] BG     = 12'h0A5;
    localparam logic [11:0] TRANSP = 12'hF0F;

    logic          clk = 1'b0;
    logic          rst;
    logic [10:0]   curr_x;
    logic [9:0]    curr_y;
    logic          video_en;
    logic          frame_start;
    logic [11*NS-1:0] spr_pos_x;
    logic [10*NS-1:0] spr_pos_y;
    logic [FW*NS-1:0] spr_frame;
    logic [NS-1:0] spr_en;
    logic [11:0]   bg_color;
    logic [AW-1:0] rom_addr;
    logic [11:0]   rom_data;
    logic [3:0]    o_pix_r, o_pix_g, o_pix_b;
    logic          o_video_en, o_hit_valid;
    logic [2:0]    o_hit_id;

    always #5 clk = ~clk;

    sprite_layer_renderer #(
        .NUM_SPRITES(NS), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .NUM_FRAMES(NF),
        .FRAME_W(FW), .COLOR_WIDTH(12), .ADDR_WIDTH(AW), .TRANSPARENT(TRANSP)
    ) dut (
        .clk(clk), .rst(rst), .curr_x(curr_x), .curr_y(curr_y),
        .video_en(video_en), .frame_start(frame_start),
        .spr_pos_x(spr_pos_x), .spr_pos_y(spr_pos_y), .spr_frame(spr_frame),
        .spr_en(spr_en), .bg_color(bg_color), .rom_addr(rom_addr),
        .rom_data(rom_data), .o_pix_r(o_pix_r), .o_pix_g(o_pix_g),
        .o_pix_b(o_pix_b), .o_video_en(o_video_en), .o_hit_valid(o_hit_valid),
        .o_hit_id(o_hit_id)
    );

    logic [11:0] rom [0:(1<<AW)-1];
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        bit          ven;
        int          addr;
        bit          hit;
        int          id;
        logic [11:0] data;
    } exp_t;

    int lx[NS], ly[NS], lf[NS];
    bit le[NS];
    int sx[NS], sy[NS], sf[NS];
    bit se[NS];
    int passCount  = 0;
    int checkCount = 0;

    task automatic driveAttrs();
        for (int i = 0; i < NS; i++) begin
            spr_pos_x[11*i +: 11] = 11'(lx[i]);
            spr_pos_y[10*i +: 10] = 10'(ly[i]);
            spr_frame[FW*i +: FW] = FW'(lf[i]);
            spr_en[i]             = le[i];
        end
    endtask

    task automatic latchShadows();
        for (int i = 0; i < NS; i++) begin
            sx[i] = lx[i]; sy[i] = ly[i]; sf[i] = lf[i]; se[i] = le[i];
        end
    endtask

    task automatic clearSprites();
        for (int i = 0; i < NS; i++) begin
            lx[i] = 0; ly[i] = 0; lf[i] = 0; le[i] = 1'b0;
        end
    endtask

    task automatic randAttrs();
        for (int i = 0; i < NS; i++) begin
            lx[i] = $urandom_range(0, 300);
            ly[i] = $urandom_range(0, 200);
            lf[i] = $urandom_range(0, 5);
            le[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic frameStart();
        driveAttrs();
        frame_start = 1'b1;
        video_en    = 1'b0;
        @(posedge clk); #1;
        frame_start = 1'b0;
        latchShadows();
    endtask

    // Reference: first enabled, in-range sprite whose rectangle contains the pixel.
    function automatic exp_t model(int x, int y, bit ven);
        exp_t e;
        e.ven = ven; e.addr = 0; e.hit = 1'b0; e.id = 0; e.data = '0;
        if (!ven) return e;
        for (int i = 0; i < NS; i++) begin
            if (se[i] && sf[i] < NF && x >= sx[i] && x < sx[i] + IW
                && y >= sy[i] && y < sy[i] + IH) begin
                e.addr = (sf[i] * IW * IH + (y - sy[i]) * IW + (x - sx[i])) % (1 << AW);
                e.data = rom[e.addr];
                e.hit  = (e.data != TRANSP);
                e.id   = e.hit ? i : 0;
                return e;
            end
        end
        return e;
    endfunction

    function automatic logic [11:0] expPix(exp_t e, logic [11:0] bg);
        if (!e.ven) return 12'h000;
        return e.hit ? e.data : bg;
    endfunction

    task automatic scanPixel(input int x, input int y, input bit fs,
                             output logic [AW-1:0] a, output logic [11:0] pix,
                             output logic hv, output logic [2:0] hid, output logic ove);
        curr_x = 11'(x); curr_y = 10'(y); video_en = 1'b1; frame_start = fs;
        @(posedge clk); #1;
        a = rom_addr;
        if (fs) latchShadows();
        video_en = 1'b0; frame_start = 1'b0; curr_x = '0; curr_y = '0;
        repeat (2) begin @(posedge clk); #1; end
        pix = {o_pix_r, o_pix_g, o_pix_b};
        hv  = o_hit_valid;
        hid = o_hit_id;
        ove = o_video_en;
    endtask

    task automatic test_reset();
        logic [AW-1:0] a; logic [11:0] pix; logic hv, ove; logic [2:0] hid; exp_t e;
        rst = 1'b0; video_en = 1'b1; curr_x = 11'd100; curr_y = 10'd50; bg_color = BG;
        clearSprites();
        le[0] = 1'b1; lx[0] = 100; ly[0] = 50; lf[0] = 1;
        driveAttrs();
        frame_start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkCount++;
            if ({rom_addr, o_pix_r, o_pix_g, o_pix_b, o_video_en, o_hit_valid, o_hit_id} !== '0)
                $display("[TB] FAIL reset_state cycle %0d: got %h expected 0", c,
                         {rom_addr, o_pix_r, o_pix_g, o_pix_b, o_video_en, o_hit_valid, o_hit_id});
            else passCount++;
        end
        rst = 1'b1; frame_start = 1'b0; video_en = 1'b0;
        for (int i = 0; i < NS; i++) se[i] = 1'b0;
        // frame_start held during reset must not have enabled sprite 0
        e = model(100, 50, 1'b1);
        scanPixel(100, 50, 1'b0, a, pix, hv, hid, ove);
        checkCount++;
        if (hv !== 1'b0) $display("[TB] FAIL reset_overrides_fs hit: got %b expected 0", hv);
        else passCount++;
        checkCount++;
        if (pix !== expPix(e, BG)) $display("[TB] FAIL reset_overrides_fs pix: got %h expected %h", pix, expPix(e, BG));
        else passCount++;
    endtask

    task automatic test_single_sprite();
        logic [AW-1:0] a; logic [11:0] pix; logic hv, ove; logic [2:0] hid;
        frameStart();
        scanPixel(100, 50, 1'b0, a, pix, hv, hid, ove);
        checkCount++;
        if (a !== 14'd4096) $display("[TB] FAIL single_addr: got %0d expected 4096", a);
        else passCount++;
        checkCount++;
        if (pix !== rom[4096]) $display("[TB] FAIL single_pix: got %h expected %h", pix, rom[4096]);
        else passCount++;
        checkCount++;
        if ({hv, hid, ove} !== {1'b1, 3'd0, 1'b1})
            $display("[TB] FAIL single_flags: got hit=%b id=%0d ven=%b expected 1/0/1", hv, hid, ove);
        else passCount++;
    endtask

    task automatic test_edges();
        logic [AW-1:0] a; logic [11:0] pix; logic hv, ove; logic [2:0] hid; exp_t e;
        int pts [7][3];
        pts = '{'{99, 50, 0}, '{100, 50, 1}, '{163, 50, 1}, '{164, 50, 0},
                '{100, 49, 0}, '{100, 114, 0}, '{163, 113, 1}};
        for (int p = 0; p < 7; p++) begin
            e = model(pts[p][0], pts[p][1], 1'b1);
            scanPixel(pts[p][0], pts[p][1], 1'b0, a, pix, hv, hid, ove);
            checkCount++;
            if (hv !== 1'(pts[p][2]))
                $display("[TB] FAIL edge_hit (%0d,%0d): got %b expected %0d", pts[p][0], pts[p][1], hv, pts[p][2]);
            else passCount++;
            checkCount++;
            if (pix !== expPix(e, BG) || a !== AW'(e.addr))
                $display("[TB] FAIL edge_pix (%0d,%0d): got pix=%h addr=%0d expected %h/%0d",
                         pts[p][0], pts[p][1], pix, a, expPix(e, BG), e.addr);
            else passCount++;
        end
        checkCount++;
        if (a !== 14'd8191) $display("[TB] FAIL frame_last_addr: got %0d expected 8191", a);
        else passCount++;
    endtask

    task automatic test_overlap_transparency();
        logic [AW-1:0] a; logic [11:0] pix; logic hv, ove; logic [2:0] hid; exp_t e;
        logic [11:0] saved;
        int t [4][3];
        clearSprites();
        le[0] = 1'b1; lx[0] = 180; ly[0] = 190; lf[0] = 2;
        le[2] = 1'b1; lx[2] = 170; ly[2] = 170; lf[2] = 0;
        frameStart();
        t = '{'{200, 200, 0}, '{175, 175, 2}, '{240, 250, 0}, '{230, 180, 2}};
        for (int p = 0; p < 4; p++) begin
            e = model(t[p][0], t[p][1], 1'b1);
            scanPixel(t[p][0], t[p][1], 1'b0, a, pix, hv, hid, ove);
            checkCount++;
            if ({hv, hid} !== {1'b1, 3'(t[p][2])})
                $display("[TB] FAIL overlap_id (%0d,%0d): got hit=%b id=%0d expected 1/%0d", t[p][0], t[p][1], hv, hid, t[p][2]);
            else passCount++;
            checkCount++;
            if (pix !== expPix(e, BG)) $display("[TB] FAIL overlap_pix: got %h expected %h", pix, expPix(e, BG));
            else passCount++;
        end
        saved = rom[8852];
        rom[8852] = TRANSP;
        scanPixel(200, 200, 1'b0, a, pix, hv, hid, ove);
        checkCount++;
        if ({a, pix, hv, hid} !== {14'd8852, BG, 1'b0, 3'd0})
            $display("[TB] FAIL transparent: got addr=%0d pix=%h hit=%b id=%0d expected 8852/%h/0/0", a, pix, hv, hid, BG);
        else passCount++;
        rom[8852] = saved;
    endtask

    task automatic test_shadowing();
        logic [AW-1:0] a; logic [11:0] pix; logic hv, ove; logic [2:0] hid; exp_t e;
        lx[0] = 400;
        driveAttrs();
        scanPixel(200, 200, 1'b0, a, pix, hv, hid, ove);
        checkCount++;
        if ({hv, hid} !== {1'b1, 3'd0}) $display("[TB] FAIL shadow_hold: got hit=%b id=%0d expected 1/0", hv, hid);
        else passCount++;
        scanPixel(200, 200, 1'b1, a, pix, hv, hid, ove);
        checkCount++;
        if ({hv, hid} !== {1'b1, 3'd0}) $display("[TB] FAIL shadow_same_cycle: got hit=%b id=%0d expected 1/0", hv, hid);
        else passCount++;
        e = model(200, 200, 1'b1);
        scanPixel(200, 200, 1'b0, a, pix, hv, hid, ove);
        checkCount++;
        if ({hv, hid, pix} !== {1'b1, 3'd2, expPix(e, BG)})
            $display("[TB] FAIL shadow_moved_away: got hit=%b id=%0d pix=%h expected 1/2/%h", hv, hid, pix, expPix(e, BG));
        else passCount++;
        scanPixel(410, 200, 1'b0, a, pix, hv, hid, ove);
        checkCount++;
        if ({hv, hid} !== {1'b1, 3'd0}) $display("[TB] FAIL shadow_new_pos: got hit=%b id=%0d expected 1/0", hv, hid);
        else passCount++;
        lf[0] = 5;
        frameStart();
        scanPixel(410, 200, 1'b0, a, pix, hv, hid, ove);
        checkCount++;
        if ({hv, pix, a} !== {1'b0, BG, 14'd0})
            $display("[TB] FAIL frame_out_of_range: got hit=%b pix=%h addr=%0d expected 0/%h/0", hv, pix, a, BG);
        else passCount++;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a; logic [11:0] pix; logic hv, ove; logic [2:0] hid;
        int xs [4];
        clearSprites();
        le[1] = 1'b1; lx[1] = 2020; ly[1] = 300; lf[1] = 3;
        frameStart();
        xs = '{0, 10, 27, 40};
        for (int p = 0; p < 4; p++) begin
            scanPixel(xs[p], 310, 1'b0, a, pix, hv, hid, ove);
            checkCount++;
            if ({hv, pix} !== {1'b0, BG}) $display("[TB] FAIL wrap_x x=%0d: got hit=%b pix=%h expected 0/%h", xs[p], hv, pix, BG);
            else passCount++;
        end
        scanPixel(2047, 310, 1'b0, a, pix, hv, hid, ove);
        checkCount++;
        if ({hv, hid, a} !== {1'b1, 3'd1, 14'd12955})
            $display("[TB] FAIL right_edge: got hit=%b id=%0d addr=%0d expected 1/1/12955", hv, hid, a);
        else passCount++;
        le[3] = 1'b1; lx[3] = 500; ly[3] = 1000; lf[3] = 0;
        frameStart();
        scanPixel(510, 5, 1'b0, a, pix, hv, hid, ove);
        checkCount++;
        if (hv !== 1'b0) $display("[TB] FAIL wrap_y: got hit=%b expected 0", hv);
        else passCount++;
        scanPixel(510, 1023, 1'b0, a, pix, hv, hid, ove);
        checkCount++;
        if ({hv, hid, a} !== {1'b1, 3'd3, 14'd1482})
            $display("[TB] FAIL bottom_edge: got hit=%b id=%0d addr=%0d expected 1/3/1482", hv, hid, a);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        exp_t hist[$];
        logic [11:0] bgNow;
        logic [11:0] expP;
        bit fs, ven;
        int x, y;
        for (int n = 0; n < 300; n++) rom[$urandom_range(0, (1 << AW) - 1)] = TRANSP;
        randAttrs();
        frameStart();
        for (int k = 0; k < 402; k++) begin
            fs = 1'b0; ven = 1'b0; x = 0; y = 0;
            if (k < 400) begin
                ven = ($urandom_range(0, 7) != 0);
                x   = $urandom_range(0, 420);
                y   = $urandom_range(0, 300);
                fs  = ($urandom_range(0, 39) == 0);
            end
            if (fs) begin randAttrs(); driveAttrs(); end
            hist.push_back(model(x, y, ven));
            curr_x = 11'(x); curr_y = 10'(y); video_en = ven; frame_start = fs;
            bgNow = 12'($urandom);
            bg_color = bgNow;
            @(posedge clk); #1;
            if (fs) latchShadows();
            checkCount++;
            if (rom_addr !== AW'(hist[k].addr))
                $display("[TB] FAIL stream_addr k=%0d: got %0d expected %0d", k, rom_addr, hist[k].addr);
            else passCount++;
            if (k >= 2) begin
                expP = expPix(hist[k-2], bgNow);
                checkCount++;
                if ({o_pix_r, o_pix_g, o_pix_b, o_hit_valid, o_hit_id, o_video_en}
                        !== {expP, hist[k-2].hit, 3'(hist[k-2].id), hist[k-2].ven})
                    $display("[TB] FAIL stream_out k=%0d: got pix=%h hit=%b id=%0d ven=%b expected %h/%b/%0d/%b",
                             k, {o_pix_r, o_pix_g, o_pix_b}, o_hit_valid, o_hit_id, o_video_en,
                             expP, hist[k-2].hit, hist[k-2].id, hist[k-2].ven);
                else passCount++;
            end
        end
        frame_start = 1'b0; video_en = 1'b0; bg_color = BG;
    endtask

    task automatic test_reset_midline();
        logic [AW-1:0] a; logic [11:0] pix; logic hv, ove; logic [2:0] hid; exp_t e;
        clearSprites();
        le[0] = 1'b1; lx[0] = 100; ly[0] = 50; lf[0] = 1;
        bg_color = BG;
        frameStart();
        video_en = 1'b1; curr_y = 10'd50;
        for (int c = 0; c < 4; c++) begin
            curr_x = 11'(100 + c);
            @(posedge clk); #1;
        end
        rst = 1'b0; curr_x = 11'd104;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < NS; i++) se[i] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkCount++;
            if ({o_pix_r, o_pix_g, o_pix_b, o_video_en, o_hit_valid, o_hit_id} !== '0)
                $display("[TB] FAIL midline_flush cycle %0d: got %h expected 0", c,
                         {o_pix_r, o_pix_g, o_pix_b, o_video_en, o_hit_valid, o_hit_id});
            else passCount++;
            curr_x = 11'(105 + c);
            @(posedge clk); #1;
        end
        checkCount++;
        if ({o_pix_r, o_pix_g, o_pix_b, o_hit_valid, o_video_en} !== {BG, 1'b0, 1'b1})
            $display("[TB] FAIL midline_disabled: got pix=%h hit=%b ven=%b expected %h/0/1",
                     {o_pix_r, o_pix_g, o_pix_b}, o_hit_valid, o_video_en, BG);
        else passCount++;
        video_en = 1'b0;
        frameStart();
        e = model(100, 50, 1'b1);
        scanPixel(100, 50, 1'b0, a, pix, hv, hid, ove);
        checkCount++;
        if ({pix, hv, hid, a} !== {expPix(e, BG), e.hit, 3'(e.id), AW'(e.addr)})
            $display("[TB] FAIL midline_reenable: got pix=%h hit=%b id=%0d addr=%0d expected %h/%b/%0d/%0d",
                     pix, hv, hid, a, expPix(e, BG), e.hit, e.id, e.addr);
        else passCount++;
    endtask

    initial begin
        logic [11:0] v;
        rst = 1'b0; curr_x = '0; curr_y = '0; video_en = 1'b0; frame_start = 1'b0;
        spr_pos_x = '0; spr_pos_y = '0; spr_frame = '0; spr_en = '0; bg_color = BG;
        for (int i = 0; i < (1 << AW); i++) begin
            v = 12'($urandom_range(1, 4095));
            if (v == TRANSP || v == BG) v = 12'h001;
            rom[i] = v;
        end
        clearSprites();
        latchShadows();
        @(posedge clk); #1;
        test_reset();
        test_single_sprite();
        test_edges();
        test_overlap_transparency();
        test_shadowing();
        test_wrap();
        test_back_to_back();
        test_reset_midline();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
